// File: rtl/sd_datrx_pkg.sv
// Shared definitions for the SD/eMMC data-block receiver: CRC polynomial,
// bus-width encodings, FSM states and small datapath helpers.
package sd_datrx_pkg;

    localparam logic [15:0] CRC_POLYNOMIAL = 16'h1021;

    // i_width encoding; the reserved code behaves as 8-bit
    typedef enum logic [1:0] {
        SD_W1   = 2'd0,
        SD_W4   = 2'd1,
        SD_W8   = 2'd2,
        SD_WRSV = 2'd3
    } sd_width_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_START2     = 3'd2,
        ST_DATA       = 3'd3,
        ST_CRC        = 3'd4,
        ST_STOP       = 3'd5
    } sd_state_e;

    // One serial CRC16 step, MSB-first, feedback taken from crc[15]
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLYNOMIAL : 16'h0000);
    endfunction

    // DAT lanes that carry data for a given bus width
    function automatic logic [7:0] lane_mask(input sd_width_e w);
        case (w)
            SD_W1:   return 8'h01;
            SD_W4:   return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Index of the beat that completes a 32-bit word
    function automatic logic [4:0] last_beat(input sd_width_e w);
        case (w)
            SD_W1:   return 5'd31;
            SD_W4:   return 5'd7;
            default: return 5'd3;
        endcase
    endfunction

    // Shift one beat into the word register; the highest active lane is the MSB
    function automatic logic [31:0] shift_word(input logic [31:0] sreg, input sd_width_e w,
                                               input logic [7:0] dat);
        case (w)
            SD_W1:   return {sreg[30:0], dat[0]};
            SD_W4:   return {sreg[27:0], dat[3:0]};
            default: return {sreg[23:0], dat};
        endcase
    endfunction

endpackage

// File: rtl/sd_datrx_if.sv
// Control/status and data bus of the SD data receiver. The receiver takes
// the slave side; whoever arms it and consumes words takes the master side.
interface sd_datrx_if;
    logic        i_en;
    logic [1:0]  i_width;
    logic        i_ddr;
    logic [9:0]  i_length;
    logic        i_sample;
    logic [7:0]  i_dat;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
    logic        o_crcerr;
    logic        o_frameerr;
    logic        o_timeout;

    modport slave (
        input  i_en, i_width, i_ddr, i_length, i_sample, i_dat,
        output o_valid, o_data, o_last, o_busy, o_done, o_crcerr, o_frameerr, o_timeout
    );

    modport master (
        output i_en, i_width, i_ddr, i_length, i_sample, i_dat,
        input  o_valid, o_data, o_last, o_busy, o_done, o_crcerr, o_frameerr, o_timeout
    );
endinterface

// File: rtl/sd_datrx_crc16_lane.sv
// Serial CRC16 accumulator for one DAT lane (one bank). Cleared when the
// receiver arms; zero flags a clean remainder once the CRC beats are in.
module sd_crc16_lane
    import sd_datrx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic step,
    input  logic din,
    output logic zero
);
    logic [15:0] crc;

    // CRC register: clear on arm, advance one bit per qualified beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (step)
            crc <= crc16_step(crc, din);
    end

    assign zero = (crc == '0);
endmodule

// File: rtl/sd_datrx.sv
// Host-side SD/eMMC data-block receiver. Finds the start bit, assembles
// 32-bit words MSB-first from 1/4/8 lanes, checks the per-lane CRC16
// (separate pos/neg banks in DDR) and the stop beat. The card cannot be
// stalled, so every beat is consumed on its i_sample strobe.
module sd_datrx
    import sd_datrx_pkg::*;
#(
    parameter int NUMIO     = 8,
    parameter int LGTIMEOUT = 23,
    parameter bit OPT_DDR   = 1'b1
) (
    input logic       i_clk,
    input logic       i_reset_n,
    sd_datrx_if.slave bus
);
    localparam logic [7:0] IO_MASK = 8'((17'h1 << NUMIO) - 17'h1);

    sd_state_e state, state_next;

    logic                 en_q;
    sd_width_e            width_q;
    logic                 ddr_q;
    logic [9:0]           len_q;
    logic [31:0]          sreg;
    logic [4:0]           beat_cnt;
    logic [9:0]           byte_cnt;
    logic [4:0]           crc_cnt;
    logic                 stop_cnt;
    logic                 phase;
    logic [LGTIMEOUT-1:0] timer;

    logic        valid_q, last_q, done_q, crcerr_q, frameerr_q, timeout_q;
    logic [31:0] data_q;

    logic arm, start_hit, data_beat, word_done, last_word;
    logic crc_beat, stop_beat, stop_final, timeout_hit;

    logic [7:0]       lanes;
    logic [31:0]      word_in;
    logic [9:0]       byte_next;
    logic             crc_step;
    logic [NUMIO-1:0] zero_pos, zero_neg;
    logic             crc_bad;

    assign lanes     = lane_mask(width_q) & IO_MASK;
    assign word_in   = shift_word(sreg, width_q, bus.i_dat);
    // 512 bytes wraps to 0, which matches the i_length encoding of 512
    assign byte_next = byte_cnt + 10'd4;
    assign crc_step  = data_beat | crc_beat;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state and per-cycle control strobes; dropping i_en overrides all
    always_comb begin
        state_next  = state;
        arm         = 1'b0;
        start_hit   = 1'b0;
        data_beat   = 1'b0;
        word_done   = 1'b0;
        last_word   = 1'b0;
        crc_beat    = 1'b0;
        stop_beat   = 1'b0;
        stop_final  = 1'b0;
        timeout_hit = 1'b0;
        if (!bus.i_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!en_q) begin
                        arm        = 1'b1;
                        state_next = ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (bus.i_sample && !bus.i_dat[0]) begin
                        start_hit  = 1'b1;
                        state_next = ddr_q ? ST_START2 : ST_DATA;
                    end else if (timer == '1) begin
                        timeout_hit = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end
                ST_START2: begin
                    if (bus.i_sample)
                        state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (bus.i_sample) begin
                        data_beat = 1'b1;
                        if (beat_cnt == last_beat(width_q)) begin
                            word_done = 1'b1;
                            if (byte_next == len_q) begin
                                last_word  = 1'b1;
                                state_next = ST_CRC;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (bus.i_sample) begin
                        crc_beat = 1'b1;
                        if (crc_cnt == (ddr_q ? 5'd31 : 5'd15))
                            state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bus.i_sample) begin
                        stop_beat = 1'b1;
                        if (!ddr_q || stop_cnt) begin
                            stop_final = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath: block setup, word assembly, counters, pulses and sticky flags
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            en_q       <= 1'b0;
            width_q    <= SD_W1;
            ddr_q      <= 1'b0;
            len_q      <= '0;
            sreg       <= '0;
            beat_cnt   <= '0;
            byte_cnt   <= '0;
            crc_cnt    <= '0;
            stop_cnt   <= 1'b0;
            phase      <= 1'b0;
            timer      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            crcerr_q   <= 1'b0;
            frameerr_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            en_q    <= bus.i_en;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            if (arm) begin
                width_q    <= sd_width_e'(bus.i_width);
                ddr_q      <= OPT_DDR & bus.i_ddr;
                len_q      <= bus.i_length;
                timer      <= '0;
                crcerr_q   <= 1'b0;
                frameerr_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else if (state == ST_WAIT_START) begin
                timer <= timer + 1'b1;
            end
            if (start_hit) begin
                beat_cnt <= '0;
                byte_cnt <= '0;
                crc_cnt  <= '0;
                stop_cnt <= 1'b0;
                phase    <= 1'b0;
            end
            // Data and CRC beats alternate banks; data beat counts are always even
            if (crc_step)
                phase <= ~phase;
            if (data_beat) begin
                sreg     <= word_in;
                beat_cnt <= word_done ? 5'd0 : beat_cnt + 5'd1;
            end
            if (word_done) begin
                valid_q  <= 1'b1;
                data_q   <= word_in;
                last_q   <= last_word;
                byte_cnt <= byte_next;
            end
            if (crc_beat)
                crc_cnt <= crc_cnt + 5'd1;
            if (stop_beat) begin
                stop_cnt <= 1'b1;
                if ((bus.i_dat & lanes) != lanes)
                    frameerr_q <= 1'b1;
            end
            if (stop_final) begin
                done_q <= 1'b1;
                if (crc_bad)
                    crcerr_q <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
                done_q    <= 1'b1;
            end
        end
    end

    for (genvar l = 0; l < NUMIO; l++) begin : g_lane
        logic step_pos;
        assign step_pos = crc_step & lanes[l] & (~ddr_q | ~phase);

        sd_crc16_lane u_pos (
            .clk   (i_clk),
            .rst_n (i_reset_n),
            .clear (arm),
            .step  (step_pos),
            .din   (bus.i_dat[l]),
            .zero  (zero_pos[l])
        );

        if (OPT_DDR) begin : g_neg
            logic step_neg;
            assign step_neg = crc_step & lanes[l] & ddr_q & phase;

            sd_crc16_lane u_neg (
                .clk   (i_clk),
                .rst_n (i_reset_n),
                .clear (arm),
                .step  (step_neg),
                .din   (bus.i_dat[l]),
                .zero  (zero_neg[l])
            );
        end else begin : g_noneg
            assign zero_neg[l] = 1'b1;
        end
    end

    assign crc_bad = (|(~zero_pos & lanes[NUMIO-1:0])) |
                     (ddr_q & (|(~zero_neg & lanes[NUMIO-1:0])));

    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;
    assign bus.o_last     = last_q;
    assign bus.o_busy     = (state != ST_IDLE);
    assign bus.o_done     = done_q;
    assign bus.o_crcerr   = crcerr_q;
    assign bus.o_frameerr = frameerr_q;
    assign bus.o_timeout  = timeout_q;
endmodule

// File: tb/tb_sd_datrx.sv
// Directed/randomised bench for sd_datrx. Beat streams and expected words,
// CRCs and flags come from a lane/bit model of the SD block format; CRCs are
// computed by polynomial long division of each lane's bit string.
module tb_sd_datrx;
    localparam int LG = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] got_word[$];
    logic        got_last[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd_datrx_if bus();

    sd_datrx #(.NUMIO(8), .LGTIMEOUT(LG), .OPT_DDR(1'b1)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    // Output recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_valid) begin
            got_word.push_back(bus.o_data);
            got_last.push_back(bus.o_last);
        end
        if (bus.o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remainder of msg(x) * x^16 divided by x^16 + x^12 + x^5 + 1
    function automatic logic [15:0] crc_div(input bit msg[$]);
        bit          m[$];
        logic [16:0] g = 17'h11021;
        logic [15:0] r;
        int          n = msg.size();
        m = msg;
        repeat (16) m.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (m[i])
                for (int j = 0; j < 17; j++)
                    m[i+j] = m[i+j] ^ g[16-j];
        for (int j = 0; j < 16; j++)
            r[15-j] = m[n+j];
        return r;
    endfunction

    task automatic arm(input logic [1:0] w, input bit ddr, input int len);
        bus.i_en     = 1'b0;
        bus.i_sample = 1'b0;
        tick();
        bus.i_width  = w;
        bus.i_ddr    = ddr;
        bus.i_length = 10'(len);
        bus.i_en     = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) begin
            bus.i_sample = 1'b0;
            bus.i_dat    = 8'($urandom);
            tick();
        end
        bus.i_sample = 1'b1;
        bus.i_dat    = b;
        tick();
        bus.i_sample = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [1:0] w, input bit ddr, input int len,
                             input logic [31:0] words[$], input int flip_lane,
                             input int bad_stop_lane, input int abort_at);
        int          lw  = (w == 2'd0) ? 1 : (w == 2'd1) ? 4 : 8;
        int          nw  = len / 4;
        int          bpw = 32 / lw;
        bit          bits[$];
        logic [7:0]  dbeats[$];
        logic [15:0] crc[8][2];
        logic [7:0]  b;
        logic [7:0]  amask;
        int          nb, w0, d0, exp_words;
        bit          aborted = 1'b0;

        amask = (lw == 1) ? 8'h01 : (lw == 4) ? 8'h0f : 8'hff;
        for (int i = 0; i < nw; i++)
            for (int j = 31; j >= 0; j--)
                bits.push_back(words[i][j]);
        nb = bits.size() / lw;
        for (int k = 0; k < nb; k++) begin
            b = 8'($urandom);
            for (int l = 0; l < lw; l++)
                b[l] = bits[k*lw + lw - 1 - l];
            dbeats.push_back(b);
        end
        for (int l = 0; l < lw; l++)
            for (int bk = 0; bk < 2; bk++) begin
                bit q[$];
                for (int k = 0; k < nb; k++)
                    if ((ddr ? (k % 2) : 0) == bk)
                        q.push_back(dbeats[k][l]);
                crc[l][bk] = crc_div(q);
            end

        w0 = got_word.size();
        d0 = done_cnt;
        arm(w, ddr, len);
        repeat ($urandom_range(0, 3)) send(8'($urandom) | 8'h01);
        send(8'($urandom) & 8'hfe);
        if (ddr)
            send(8'($urandom));

        for (int k = 0; k < nb && !aborted; k++) begin
            if (k == abort_at) begin
                bus.i_en     = 1'b0;
                bus.i_sample = 1'b1;
                bus.i_dat    = dbeats[k];
                tick();
                bus.i_sample = 1'b0;
                aborted      = 1'b1;
            end else begin
                send(dbeats[k]);
            end
        end

        if (aborted) begin
            chk({tag, ".busy_after_abort"}, bus.o_busy, 0);
            repeat (4) tick();
            exp_words = abort_at / bpw;
            chk({tag, ".words"}, 32'(got_word.size() - w0), 32'(exp_words));
            chk({tag, ".no_done"}, 32'(done_cnt - d0), 0);
        end else begin
            for (int j = 0; j < (ddr ? 32 : 16); j++) begin
                b = 8'($urandom);
                for (int l = 0; l < lw; l++)
                    b[l] = ddr ? crc[l][j % 2][15 - j/2] : crc[l][0][15 - j];
                if (j == 3 && flip_lane >= 0)
                    b[flip_lane] = ~b[flip_lane];
                send(b);
            end
            b = 8'($urandom) | amask;
            if (bad_stop_lane >= 0)
                b[bad_stop_lane] = 1'b0;
            send(b);
            if (ddr)
                send(8'($urandom) | amask);
            for (int i = 0; i < 20 && done_cnt == d0; i++)
                tick();
            chk({tag, ".done"}, 32'(done_cnt - d0), 1);
            chk({tag, ".words"}, 32'(got_word.size() - w0), 32'(nw));
            for (int i = 0; i < nw; i++)
                if (w0 + i < got_word.size()) begin
                    chk($sformatf("%s.word%0d", tag, i), got_word[w0+i], words[i]);
                    chk($sformatf("%s.last%0d", tag, i), got_last[w0+i], (i == nw - 1));
                end
            chk({tag, ".crcerr"}, bus.o_crcerr, (flip_lane >= 0));
            chk({tag, ".frameerr"}, bus.o_frameerr, (bad_stop_lane >= 0));
            chk({tag, ".timeout"}, bus.o_timeout, 0);
            repeat (3) tick();
            chk({tag, ".idle_no_rearm"}, bus.o_busy, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wq[$];
        int          arm_cyc, d0;

        bus.i_en = 1'b0; bus.i_width = '0; bus.i_ddr = 1'b0;
        bus.i_length = '0; bus.i_sample = 1'b0; bus.i_dat = '0;

        repeat (3) tick();
        chk("rst.valid", bus.o_valid, 0);
        chk("rst.data", bus.o_data, 0);
        chk("rst.busy", bus.o_busy, 0);
        chk("rst.done", bus.o_done, 0);
        chk("rst.flags", {bus.o_last, bus.o_crcerr, bus.o_frameerr, bus.o_timeout}, 0);
        rst_n = 1'b1;
        tick();
        chk("rst.busy_released", bus.o_busy, 0);

        // 1b SDR single word
        wq = {32'hDEADBEEF};
        run_block("t1", 2'd0, 1'b0, 4, wq, -1, -1, -1);

        // 4b SDR, full 512-byte block of incrementing words (length encoded as 0)
        wq = {};
        for (int i = 0; i < 128; i++) wq.push_back(32'(i));
        run_block("t2", 2'd1, 1'b0, 512, wq, -1, -1, -1);

        // Same block, one CRC bit corrupted on lane 2
        run_block("t3", 2'd1, 1'b0, 512, wq, 2, -1, -1);

        // No start bit: timeout after 2^LG cycles in WAIT_START
        arm(2'd0, 1'b0, 4);
        arm_cyc = cyc;
        d0      = done_cnt;
        chk("t4.busy", bus.o_busy, 1);
        for (int i = 0; i < (1 << LG) + 20 && done_cnt == d0; i++) begin
            bus.i_sample = 1'($urandom_range(0, 1));
            bus.i_dat    = 8'($urandom) | 8'h01;
            tick();
        end
        bus.i_sample = 1'b0;
        chk("t4.done", 32'(done_cnt - d0), 1);
        chk("t4.done_cycle", 32'(done_cyc - arm_cyc), 32'(1 << LG));
        chk("t4.timeout", bus.o_timeout, 1);
        chk("t4.busy_end", bus.o_busy, 0);
        chk("t4.other_flags", {bus.o_crcerr, bus.o_frameerr}, 0);

        // 8b DDR, 2 words, stop beat lane 5 low
        wq = {32'($urandom), 32'($urandom)};
        run_block("t5", 2'd2, 1'b1, 8, wq, -1, 5, -1);

        // Abort mid-DATA (after one word), then a clean re-armed block
        wq = {32'($urandom), 32'($urandom)};
        run_block("t6a", 2'd0, 1'b0, 8, wq, -1, -1, 40);
        wq = {32'hDEADBEEF};
        run_block("t6b", 2'd0, 1'b0, 4, wq, -1, -1, -1);

        // Abort on the word-completing beat suppresses that word
        wq = {32'($urandom), 32'($urandom)};
        run_block("t7", 2'd2, 1'b0, 8, wq, -1, -1, 3);

        // Randomised blocks over widths and modes
        for (int r = 0; r < 4; r++) begin
            int          len;
            logic [1:0]  w;
            bit          ddr;
            w   = 2'($urandom_range(0, 3));
            ddr = 1'($urandom_range(0, 1));
            len = 4 * $urandom_range(1, 12);
            wq  = {};
            for (int i = 0; i < len / 4; i++) wq.push_back($urandom);
            run_block($sformatf("r%0d", r), w, ddr, len, wq, -1, -1, -1);
        end
        wq = {};
        for (int i = 0; i < 128; i++) wq.push_back($urandom);
        run_block("r8ddr512", 2'd2, 1'b1, 512, wq, 7, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
